// File: rtl/calc_entry_fsm.sv
// Calculator key-entry FSM: builds two BCD operands and an operator.
// Define CALC_CHAIN_EN to chain an operator key in S_RESULT from result.
module calc_entry_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [31:0] result,
  output logic [31:0] numberOne,
  output logic [31:0] numberTwo,
  output logic [31:0] operation,
  output logic [1:0]  op_code,
  output logic        flag_NumberOne,
  output logic        flag_Operation,
  output logic        flag_NumberTwo,
  output logic        flag_Enter,
  output logic        calc_start
);

  typedef enum logic [1:0] {
    S_NUM1,
    S_OP,
    S_NUM2,
    S_RESULT
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [31:0] num1Q;
  logic [31:0] num1D;
  logic [31:0] num2Q;
  logic [31:0] num2D;
  logic [3:0]  opQ;
  logic [3:0]  opD;
  logic [1:0]  codeQ;
  logic [1:0]  codeD;
  logic [3:0]  cnt1Q;
  logic [3:0]  cnt1D;
  logic [3:0]  cnt2Q;
  logic [3:0]  cnt2D;
  logic        startQ;
  logic        startD;

  logic isDigit;
  logic isOper;
  logic isEnter;
  logic isClear;

  assign isDigit = key_code <= 4'd9;
  assign isOper  = (key_code >= 4'd10) &&
                   (key_code <= 4'd13);
  assign isEnter = key_code == 4'd14;
  assign isClear = key_code == 4'd15;

`ifndef CALC_CHAIN_EN
  logic unusedResult;
  assign unusedResult = ^result;
`endif

  // Next-state and datapath update for one consumed key.
  always_comb begin
    stateNext = state;
    num1D     = num1Q;
    num2D     = num2Q;
    opD       = opQ;
    codeD     = codeQ;
    cnt1D     = cnt1Q;
    cnt2D     = cnt2Q;
    startD    = 1'b0;
    if (key_valid) begin
      if (isClear) begin
        stateNext = S_NUM1;
        num1D     = '0;
        num2D     = '0;
        opD       = '0;
        codeD     = '0;
        cnt1D     = '0;
        cnt2D     = '0;
      end else begin
        unique case (state)
          S_NUM1: begin
            if (isDigit && cnt1Q < 4'd8) begin
              num1D = {num1Q[27:0], key_code};
              cnt1D = cnt1Q + 4'd1;
            end else if (isOper &&
                         cnt1Q != 4'd0) begin
              opD       = key_code;
              codeD     = key_code[1:0] - 2'd2;
              stateNext = S_OP;
            end
          end
          S_OP: begin
            if (isDigit) begin
              num2D     = {28'd0, key_code};
              cnt2D     = 4'd1;
              stateNext = S_NUM2;
            end else if (isOper) begin
              opD   = key_code;
              codeD = key_code[1:0] - 2'd2;
            end
          end
          S_NUM2: begin
            if (isDigit && cnt2Q < 4'd8) begin
              num2D = {num2Q[27:0], key_code};
              cnt2D = cnt2Q + 4'd1;
            end else if (isEnter &&
                         cnt2Q != 4'd0) begin
              stateNext = S_RESULT;
              startD    = 1'b1;
            end
          end
          S_RESULT: begin
            if (isDigit) begin
              num1D     = {28'd0, key_code};
              cnt1D     = 4'd1;
              num2D     = '0;
              cnt2D     = '0;
              opD       = '0;
              codeD     = '0;
              stateNext = S_NUM1;
            end
`ifdef CALC_CHAIN_EN
            else if (isOper) begin
              num1D     = result;
              cnt1D     = 4'd8;
              num2D     = '0;
              cnt2D     = '0;
              opD       = key_code;
              codeD     = key_code[1:0] - 2'd2;
              stateNext = S_OP;
            end
`endif
          end
          default: stateNext = S_NUM1;
        endcase
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_NUM1;
      num1Q  <= '0;
      num2Q  <= '0;
      opQ    <= '0;
      codeQ  <= '0;
      cnt1Q  <= '0;
      cnt2Q  <= '0;
      startQ <= 1'b0;
    end else begin
      state  <= stateNext;
      num1Q  <= num1D;
      num2Q  <= num2D;
      opQ    <= opD;
      codeQ  <= codeD;
      cnt1Q  <= cnt1D;
      cnt2Q  <= cnt2D;
      startQ <= startD;
    end
  end

  assign numberOne  = num1Q;
  assign numberTwo  = num2Q;
  assign operation  = {28'd0, opQ};
  assign op_code    = codeQ;
  assign calc_start = startQ;

  assign flag_NumberOne = state != S_NUM1;
  assign flag_Operation = (state == S_NUM2) ||
                          (state == S_RESULT);
  assign flag_NumberTwo = state == S_RESULT;
  assign flag_Enter     = state == S_RESULT;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: digit-queue model plus directed sequences.
// Build with or without CALC_CHAIN_EN to match the design.
module tb_calc_entry_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] resultIn;
  logic [31:0] numberOne;
  logic [31:0] numberTwo;
  logic [31:0] operation;
  logic [1:0]  op_code;
  logic        flag_NumberOne;
  logic        flag_Operation;
  logic        flag_NumberTwo;
  logic        flag_Enter;
  logic        calc_start;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit checkEn = 0;

  calc_entry_fsm dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .result(resultIn),
    .numberOne(numberOne),
    .numberTwo(numberTwo),
    .operation(operation),
    .op_code(op_code),
    .flag_NumberOne(flag_NumberOne),
    .flag_Operation(flag_Operation),
    .flag_NumberTwo(flag_NumberTwo),
    .flag_Enter(flag_Enter),
    .calc_start(calc_start)
  );

  always #5 clk = ~clk;

  // Model: operands as lists of entered digits, phase 0..3.
  int mPhase;
  int n1[$];
  int n2[$];
  int mOp;
  bit mStart;

  function automatic logic [31:0] pack(input int q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v = (v << 4) | 32'(q[i]);
    return v;
  endfunction

  function automatic logic [3:0] flagsOf(input int p);
    case (p)
      0:       return 4'b0000;
      1:       return 4'b1000;
      2:       return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic mReset();
    mPhase = 0;
    n1.delete();
    n2.delete();
    mOp = 0;
    mStart = 0;
  endtask

  task automatic apply(input int k);
    if (k == 15) begin
      mReset();
    end else if (k <= 9) begin
      case (mPhase)
        0: if (n1.size() < 8) n1.push_back(k);
        1: begin
          n2.delete();
          n2.push_back(k);
          mPhase = 2;
        end
        2: if (n2.size() < 8) n2.push_back(k);
        default: begin
          n1.delete();
          n2.delete();
          n1.push_back(k);
          mOp = 0;
          mPhase = 0;
        end
      endcase
    end else if (k <= 13) begin
      if (mPhase == 0 && n1.size() > 0) begin
        mOp = k;
        mPhase = 1;
      end else if (mPhase == 1) begin
        mOp = k;
      end
`ifdef CALC_CHAIN_EN
      else if (mPhase == 3) begin
        n1.delete();
        n2.delete();
        for (int i = 7; i >= 0; i--)
          n1.push_back(int'((resultIn >> (4 * i)) & 32'hF));
        mOp = k;
        mPhase = 1;
      end
`endif
    end else begin
      if (mPhase == 2 && n2.size() > 0) begin
        mPhase = 3;
        mStart = 1;
      end
    end
  endtask

  // Model advances on each clock using the inputs sampled at the edge.
  always @(posedge clk) begin : modelProc
    logic v;
    logic [3:0] k;
    logic r;
    v = key_valid;
    k = key_code;
    r = rst_n;
    #1;
    mStart = 0;
    if (!r) mReset();
    else if (v) apply(int'(k));
  end

  task automatic cmp(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h",
               name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      cmp("m.numberOne", numberOne, pack(n1));
      cmp("m.numberTwo", numberTwo, pack(n2));
      cmp("m.operation", operation, 32'(mOp));
      cmp("m.op_code", {30'd0, op_code},
          (mOp == 0) ? 32'd0 : 32'(mOp - 10));
      cmp("m.flags",
          {28'd0, flag_NumberOne, flag_Operation,
           flag_NumberTwo, flag_Enter},
          {28'd0, flagsOf(mPhase)});
      cmp("m.calc_start", {31'd0, calc_start},
          {31'd0, mStart});
      if (calc_start) pulses++;
    end
  end

  task automatic key(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      key_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] flagVec();
    return {28'd0, flag_NumberOne, flag_Operation,
            flag_NumberTwo, flag_Enter};
  endfunction

  task automatic chkZero(input string tag);
    cmp({tag, ".numberOne"}, numberOne, 32'h0);
    cmp({tag, ".numberTwo"}, numberTwo, 32'h0);
    cmp({tag, ".operation"}, operation, 32'h0);
    cmp({tag, ".op_code"}, {30'd0, op_code}, 32'h0);
    cmp({tag, ".flags"}, flagVec(), 32'h0);
    cmp({tag, ".calc_start"}, {31'd0, calc_start}, 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    resultIn  = 32'h42;
    repeat (2) @(negedge clk);
    checkEn = 1;
    chkZero("reset");
    rst_n = 1'b1;

    pulses = 0;
    key(1); key(2); key(10); key(3); key(14);
    idle(1);
    cmp("seq.numberOne", numberOne, 32'h12);
    cmp("seq.operation", operation, 32'hA);
    cmp("seq.numberTwo", numberTwo, 32'h3);
    cmp("seq.flags", flagVec(), 32'hF);
    cmp("seq.calc_start", {31'd0, calc_start}, 32'd1);
    idle(3);
    cmp("seq.pulses", 32'(pulses), 32'd1);

    key(10);
    idle(1);
`ifdef CALC_CHAIN_EN
    cmp("chain.numberOne", numberOne, 32'h42);
    cmp("chain.flags", flagVec(), 32'h8);
    cmp("chain.numberTwo", numberTwo, 32'h0);
`else
    cmp("chain.numberOne", numberOne, 32'h12);
    cmp("chain.flags", flagVec(), 32'hF);
`endif

    key(15);
    idle(1);
    chkZero("clear1");

    repeat (9) key(9);
    idle(1);
    cmp("sat.numberOne", numberOne, 32'h99999999);
    key(9);
    idle(1);
    cmp("sat.held", numberOne, 32'h99999999);

    key(15); key(5); key(11); key(12);
    idle(1);
    cmp("ovr.operation", operation, 32'hC);
    cmp("ovr.op_code", {30'd0, op_code}, 32'd2);
    cmp("ovr.flags", flagVec(), 32'h8);

    key(15); key(7); key(10); key(4); key(15);
    idle(1);
    chkZero("clear2");

    key(7); key(10); key(4);
    @(negedge clk);
    key_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chkZero("rstmid");

    pulses = 0;
    key(14); key(10);
    idle(1);
    chkZero("ignore");
    cmp("ignore.pulses", 32'(pulses), 32'd0);

    key(1); key(10); key(2); key(11);
    idle(1);
    cmp("num2op.operation", operation, 32'hA);
    cmp("num2op.flags", flagVec(), 32'hC);
    key(14);
    idle(1);
    cmp("rststart.pulse", {31'd0, calc_start}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    idle(3);
    chkZero("rststart");
    cmp("rststart.pulses", 32'(pulses), 32'd0);

    key(1); key(10); key(2); key(14); key(5);
    idle(1);
    cmp("redo.numberOne", numberOne, 32'h5);
    cmp("redo.numberTwo", numberTwo, 32'h0);
    cmp("redo.operation", operation, 32'h0);
    cmp("redo.flags", flagVec(), 32'h0);

    key_code = 4'd3;
    idle(3);
    cmp("novalid.numberOne", numberOne, 32'h5);

    key(15); key(1); key(10);
    repeat (9) key(8);
    idle(1);
    cmp("sat2.numberTwo", numberTwo, 32'h88888888);

    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd15;
    rst_n     = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    rst_n     = 1'b1;
    chkZero("clrrst");
    idle(2);

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entry_fsm.md
CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
REQ-002 It SHALL have these key-input ports:
- key_valid  input  1  one-cycle strobe; key_code is valid only while high
- key_code  input  4  0-9 digit; 10 add; 11 sub; 12 mul; 13 div; 14 enter; 15 clear
REQ-003 It SHALL have this result-input port:
- result  input  32  8-digit packed BCD result from the arithmetic stage
REQ-004 It SHALL have these operand and operation output ports:
- numberOne  output  32  first operand, packed BCD, digit 0 in bits [3:0]
- numberTwo  output  32  second operand, packed BCD
- operation  output  32  bits [3:0] hold the captured operator key code (10-13); bits [31:4] are 0
- op_code  output  2  captured operator as key_code-10
REQ-005 It SHALL have these state-flag and control output ports:
- flag_NumberOne  output  1  1 = first operand closed
- flag_Operation  output  1  1 = operator closed
- flag_NumberTwo  output  1  1 = second operand closed
- flag_Enter  output  1  1 = result being shown
- calc_start  output  1  one-cycle pulse requesting computation

Function
REQ-006 The FSM SHALL have four states: S_NUM1, S_OP, S_NUM2 and S_RESULT.
REQ-007 The state-to-flag map (flag_NumberOne, flag_Operation, flag_NumberTwo, flag_Enter) SHALL be:
- S_NUM1 = 0,0,0,0
- S_OP = 1,0,0,0
- S_NUM2 = 1,1,0,0
- S_RESULT = 1,1,1,1
REQ-008 Flags SHALL be registered, and each output change SHALL appear on the cycle after the key_valid edge.
REQ-009 A digit in S_NUM1 or S_NUM2 SHALL shift the active operand left 4 bits, insert the digit at [3:0], and increment that operand's 4-bit digit count.
REQ-010 A digit with digit count = 8 SHALL be ignored: no shift, count held.
REQ-011 An operator key in S_NUM1 with count >= 1 SHALL capture operation and op_code, then go to S_OP.
REQ-012 An operator key in S_NUM1 with count = 0 SHALL be ignored.
REQ-013 An operator key in S_OP SHALL overwrite operation and op_code and remain in S_OP.
REQ-014 A digit in S_OP SHALL set numberTwo = digit and count2 = 1, then go to S_NUM2.
REQ-015 Enter in S_NUM2 with count2 >= 1 SHALL go to S_RESULT and assert calc_start for exactly 1 cycle.
REQ-016 Enter in every other case SHALL be ignored.
REQ-017 An operator key in S_NUM2 SHALL be ignored.
REQ-018 A digit in S_RESULT SHALL clear all operands, counts and operation, load the digit as numberOne with count1 = 1, and go to S_NUM1.
REQ-019 Clear (15) in any state SHALL restore the reset values of REQ-022 on the next cycle; a clear coincident with reset has no further effect.
REQ-020 Key codes are ignored while key_valid = 0.
REQ-021 Exactly one key SHALL be consumed per key_valid cycle; back-to-back strobes SHALL each be processed.

Reset
REQ-022 When rst_n = 0 at a clk edge, the block SHALL set:
- state = S_NUM1
- numberOne, numberTwo and operation = 0
- op_code = 0
- both counts = 0
- all flags = 0
- calc_start = 0
REQ-023 A reset asserted mid-entry or during the calc_start cycle SHALL abort and discard all state, with no pending pulse afterwards.

Configuration
REQ-024 Macro CALC_CHAIN_EN SHALL control operator handling in S_RESULT.
REQ-025 With CALC_CHAIN_EN defined, an operator key in S_RESULT SHALL:
- load numberOne = result and count1 = 8
- clear numberTwo and count2
- capture the operator
- go to S_OP
REQ-026 Without CALC_CHAIN_EN, an operator key in S_RESULT SHALL be ignored, and the result input SHALL be unused.

Verification
REQ-027 Sequence keys 1,2,10,3,14 -> the bench SHALL see:
- numberOne=0x12, operation=0xA, numberTwo=0x3
- flags 1,1,1,1
- calc_start high exactly 1 cycle
REQ-028 Nine digit-9 strobes in S_NUM1 -> numberOne=0x99999999, count1=8; the 9th strobe is ignored.
REQ-029 Keys 11 then 12 in S_OP after entering 5 -> operation=0xC, op_code=2, state S_OP.
REQ-030 Entering 7,10,4 then clear -> all outputs zero and flags 0,0,0,0 on the next cycle; repeating the sequence with rst_n=0 instead of clear gives the same.
REQ-031 Enter in S_NUM1 and an operator with count1=0 -> no state change and no calc_start.
REQ-032 In S_RESULT with result=0x42, key 10 -> with CALC_CHAIN_EN: numberOne=0x42, state S_OP; without it: unchanged, still S_RESULT.
